// File: rtl/lsh_core.sv
// LSH read-mapping engine: MinHash window hasher, bucketed reference hash table
// and per-reference-window vote counters with a running argmax.
module lsh_core #(
  parameter int WINDOW_SIZE              = 128,
  parameter int KMER_SIZE                = 16,
  parameter int SKETCH_SIZE              = 16,
  parameter int NUM_OF_BUCKETS           = 256,
  parameter int BUCKET_SIZE              = 16,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512,
  parameter int MAX_WINDOWS_IN_READ      = 16,
  parameter int MIN_VOTES                = 1
) (
  input  logic                                              clk,
  input  logic                                              reset_lsh_core_n,
  input  logic                                              clear_hasher,
  input  logic                                              clear_stats,
  input  logic [2*WINDOW_SIZE-1:0]                          window,
  input  logic                                              ready_for_hashing,
  input  logic [31:0]                                       window_id,
  input  logic                                              is_insert,
  input  logic                                              is_query,
  input  logic                                              calculate_matched_window,
  output logic                                              hashing_is_done,
  output logic [SKETCH_SIZE*$clog2(NUM_OF_BUCKETS)-1:0]     hashed_sketch,
  output logic                                              table_busy,
  output logic signed [31:0]                                matched_window_id
);

  localparam int B   = $clog2(NUM_OF_BUCKETS);
  localparam int S   = SKETCH_SIZE;
  localparam int N   = WINDOW_SIZE - KMER_SIZE + 1;
  localparam int CW  = $clog2(N + 1);
  localparam int IDW = $clog2(MAX_WINDOWS_IN_REFERENCE);
  localparam int VW  = $clog2(MAX_WINDOWS_IN_READ * SKETCH_SIZE + 1);
  localparam int FW  = $clog2(BUCKET_SIZE + 1);
  localparam int SW  = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;
  localparam int XW  = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------------------------------------------------------- hasher
  logic [1:0]               h_state;
  logic [CW-1:0]            h_cnt;
  logic [2*WINDOW_SIZE-1:0] win_sr;
  logic [31:0]              mins   [S];
  logic [B-1:0]             sketch [S];
  logic [31:0]              kmer;
  logic [31:0]              hval   [S];

  // win_sr is shifted one nucleotide per k-mer, so k-mer i always sits at the bottom.
  always_comb begin
    kmer = '0;
    for (int k = 0; k < KMER_SIZE; k++) kmer = {kmer[29:0], win_sr[2*k +: 2]};
  end

  always_comb begin
    for (int s = 0; s < S; s++) hval[s] = (kmer ^ (32'(s) * 32'h9E3779B9)) * 32'h85EBCA6B;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_lsh_core_n) begin
    if (!reset_lsh_core_n) begin
      h_state         <= ST_IDLE;
      h_cnt           <= '0;
      win_sr          <= '0;
      hashing_is_done <= 1'b0;
      for (int s = 0; s < S; s++) begin
        mins[s]   <= '1;
        sketch[s] <= '0;
      end
    end else if (clear_hasher) begin
      h_state         <= ST_IDLE;
      hashing_is_done <= 1'b0;
    end else begin
      case (h_state)
        ST_IDLE: if (ready_for_hashing) begin
          win_sr  <= window;
          h_cnt   <= '0;
          for (int s = 0; s < S; s++) mins[s] <= '1;
          h_state <= ST_RUN;
        end
        ST_RUN: if (h_cnt == CW'(N)) begin
          for (int s = 0; s < S; s++) sketch[s] <= mins[s][B-1:0];
          hashing_is_done <= 1'b1;
          h_state         <= ST_DONE;
        end else begin
          for (int s = 0; s < S; s++) if (hval[s] < mins[s]) mins[s] <= hval[s];
          win_sr <= win_sr >> 2;
          h_cnt  <= h_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < S; g++) begin : g_pack
    assign hashed_sketch[B*g +: B] = sketch[g];
  end

  // ----------------------------------------------------------------- table
  logic [IDW-1:0] slots [NUM_OF_BUCKETS][BUCKET_SIZE];
  logic [FW-1:0]  fill  [NUM_OF_BUCKETS];
  logic           op_busy, op_insert;
  logic [XW-1:0]  op_idx;
  logic [IDW-1:0] op_id;
  logic           ins_q, qry_q, calc_q, calc_pend;
  logic           ins_rise, qry_rise, calc_rise;
  logic [B-1:0]   cur_b;
  logic [FW-1:0]  cur_fill, last_pos;
  logic           ins_do;

  assign ins_rise   = is_insert & ~ins_q;
  assign qry_rise   = is_query & ~qry_q;
  assign calc_rise  = calculate_matched_window & ~calc_q;
  assign table_busy = op_busy;
  assign cur_b      = sketch[op_idx];
  assign cur_fill   = fill[cur_b];
  assign last_pos   = cur_fill - 1'b1;
  // Dedup only against the newest slot: one window hitting the same bucket twice.
  assign ins_do = op_busy & op_insert & (cur_fill != FW'(BUCKET_SIZE)) &
                  ~((cur_fill != '0) & (slots[cur_b][last_pos[SW-1:0]] == op_id));

  // NOTE: slot storage is not reset; fill counts define which slots are valid.
  always_ff @(posedge clk) begin
    if (ins_do) slots[cur_b][cur_fill[SW-1:0]] <= op_id;
  end

  // ------------------------------------------------------------ vote stats
  logic [VW-1:0]  votes     [MAX_WINDOWS_IN_REFERENCE];
  logic [VW-1:0]  votes_nxt [MAX_WINDOWS_IN_REFERENCE];
  logic [IDW-1:0] best_id, best_id_nxt, vid;
  logic [VW-1:0]  best_cnt, best_cnt_nxt, vcnt;
  logic signed [31:0] result;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    votes_nxt    = votes;
    best_id_nxt  = best_id;
    best_cnt_nxt = best_cnt;
    vid          = '0;
    vcnt         = '0;
    if (op_busy && !op_insert) begin
      // Slots are applied in order so a duplicated id within a bucket counts twice.
      for (int j = 0; j < BUCKET_SIZE; j++) begin
        if (j < int'(cur_fill)) begin
          vid = slots[cur_b][j];
          if (votes_nxt[vid] != {VW{1'b1}}) votes_nxt[vid] = votes_nxt[vid] + 1'b1;
          vcnt = votes_nxt[vid];
          if (vcnt > best_cnt_nxt || (vcnt == best_cnt_nxt && vid < best_id_nxt)) begin
            best_cnt_nxt = vcnt;
            best_id_nxt  = vid;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_lsh_core_n) begin
    if (!reset_lsh_core_n || clear_stats) begin
      for (int i = 0; i < MAX_WINDOWS_IN_REFERENCE; i++) votes[i] <= '0;
      best_id  <= '0;
      best_cnt <= '0;
    end else begin
      votes    <= votes_nxt;
      best_id  <= best_id_nxt;
      best_cnt <= best_cnt_nxt;
    end
  end

  always_comb begin
    if (int'(best_cnt) >= MIN_VOTES) result = 32'(best_id);
    else                             result = -32'sd1;
  end

  // ---------------------------------------------------------- op sequencer
  always_ff @(posedge clk or negedge reset_lsh_core_n) begin
    if (!reset_lsh_core_n) begin
      op_busy           <= 1'b0;
      op_insert         <= 1'b0;
      op_idx            <= '0;
      op_id             <= '0;
      ins_q             <= 1'b0;
      qry_q             <= 1'b0;
      calc_q            <= 1'b0;
      calc_pend         <= 1'b0;
      matched_window_id <= -32'sd1;
      for (int b = 0; b < NUM_OF_BUCKETS; b++) fill[b] <= '0;
    end else begin
      ins_q  <= is_insert;
      qry_q  <= is_query;
      calc_q <= calculate_matched_window;

      if (op_busy) begin
        if (ins_do) fill[cur_b] <= cur_fill + 1'b1;
        if (op_idx == XW'(S - 1)) op_busy <= 1'b0;
        op_idx <= op_idx + 1'b1;
      end else if (ins_rise) begin
        // A simultaneous query edge is dropped even when the insert id is rejected.
        if (window_id < 32'(MAX_WINDOWS_IN_REFERENCE)) begin
          op_busy   <= 1'b1;
          op_insert <= 1'b1;
          op_idx    <= '0;
          op_id     <= window_id[IDW-1:0];
        end
      end else if (qry_rise) begin
        op_busy   <= 1'b1;
        op_insert <= 1'b0;
        op_idx    <= '0;
      end

      calc_pend <= (calc_rise | calc_pend) & op_busy;
      if (clear_stats)                          matched_window_id <= -32'sd1;
      else if ((calc_rise | calc_pend) && !op_busy) matched_window_id <= result;
    end
  end

endmodule

// File: tb/tb_lsh_core.sv
// Self-checking bench for lsh_core: table-driven hasher vectors against a MinHash
// model, plus hand-written insert/query/vote sequences with scoreboard queues.
module tb_lsh_core;
  localparam int WS = 128;
  localparam int K  = 16;
  localparam int S  = 16;
  localparam int B  = 8;
  localparam int N  = WS - K + 1;

  logic               clk = 1'b0;
  logic               reset_lsh_core_n, clear_hasher, clear_stats;
  logic [2*WS-1:0]    window;
  logic               ready_for_hashing;
  logic [31:0]        window_id;
  logic               is_insert, is_query, calculate_matched_window;
  logic               hashing_is_done;
  logic [S*B-1:0]     hashed_sketch;
  logic               table_busy;
  logic signed [31:0] matched_window_id;

  int errors = 0;
  int checks = 0;
  logic [S*B-1:0] exp_sketch_q[$];
  int             exp_id_q[$];

  typedef struct {
    logic [2*WS-1:0] win;
    logic [S*B-1:0]  sketch;
    int              lat;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  lsh_core dut (
    .clk                      (clk),
    .reset_lsh_core_n         (reset_lsh_core_n),
    .clear_hasher             (clear_hasher),
    .clear_stats              (clear_stats),
    .window                   (window),
    .ready_for_hashing        (ready_for_hashing),
    .window_id                (window_id),
    .is_insert                (is_insert),
    .is_query                 (is_query),
    .calculate_matched_window (calculate_matched_window),
    .hashing_is_done          (hashing_is_done),
    .hashed_sketch            (hashed_sketch),
    .table_busy               (table_busy),
    .matched_window_id        (matched_window_id)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [S*B-1:0] model_sketch(input logic [2*WS-1:0] w);
    logic [31:0]    mn [S];
    logic [31:0]    x, h;
    logic [S*B-1:0] r;
    for (int s = 0; s < S; s++) mn[s] = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) begin
      x = 32'd0;
      for (int k = 0; k < K; k++) x = (x << 2) | 32'(w[2*(i+k) +: 2]);
      for (int s = 0; s < S; s++) begin
        h = (x ^ (32'(s) * 32'h9E3779B9)) * 32'h85EBCA6B;
        if (h < mn[s]) mn[s] = h;
      end
    end
    r = '0;
    for (int s = 0; s < S; s++) r[B*s +: B] = mn[s][B-1:0];
    return r;
  endfunction

  function automatic logic [2*WS-1:0] rand_window();
    logic [2*WS-1:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic hash_window(input logic [2*WS-1:0] w, input logic [S*B-1:0] exp_sk,
                             output int lat);
    @(negedge clk) clear_hasher = 1'b1;
    @(negedge clk) clear_hasher = 1'b0;
    window            = w;
    ready_for_hashing = 1'b1;
    @(posedge clk);
    exp_sketch_q.push_back(exp_sk);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      ready_for_hashing = 1'b0;
      if (hashing_is_done) break;
    end
    check("hash_done", hashing_is_done, 1);
    check("sketch", hashed_sketch, exp_sketch_q.pop_front());
  endtask

  task automatic run_op(input logic ins, input logic qry, input logic [31:0] id,
                        input int hold, output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    window_id = id;
    is_insert = ins;
    is_query  = qry;
    for (int c = 0; c < 4*S + 10; c++) begin
      @(negedge clk);
      if (c + 1 == hold) begin
        is_insert = 1'b0;
        is_query  = 1'b0;
      end
      if (table_busy) busy_cycles++;
    end
  endtask

  task automatic calc(input int exp);
    @(negedge clk);
    calculate_matched_window = 1'b1;
    exp_id_q.push_back(exp);
    @(negedge clk) calculate_matched_window = 1'b0;
    for (int c = 0; c < 100 && table_busy; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("matched_id", matched_window_id, exp_id_q.pop_front());
  endtask

  task automatic pulse_clear_stats();
    @(negedge clk) clear_stats = 1'b1;
    @(negedge clk) clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset_lsh_core_n = 1'b0;
    @(negedge clk) reset_lsh_core_n = 1'b1;
  endtask

  initial begin
    logic [2*WS-1:0] wr [4];
    logic [2*WS-1:0] wb, wx;
    int lat, bc;

    reset_lsh_core_n = 1'b0;
    clear_hasher = 1'b0; clear_stats = 1'b0; window = '0; ready_for_hashing = 1'b0;
    window_id = '0; is_insert = 1'b0; is_query = 1'b0; calculate_matched_window = 1'b0;
    repeat (3) @(negedge clk);
    reset_lsh_core_n = 1'b1;
    @(negedge clk);

    check("rst_done", hashing_is_done, 0);
    check("rst_busy", table_busy, 0);
    check("rst_matched", matched_window_id, -1);
    check("rst_sketch", hashed_sketch, 0);
    calc(-1);

    // Hasher vectors: all-A, all-T, repeating ACGT, random.
    vecs[0].win = '0;
    vecs[1].win = '1;
    for (int j = 0; j < WS; j++) vecs[2].win[2*j +: 2] = 2'(j % 4);
    vecs[3].win = rand_window();
    for (int i = 0; i < 4; i++) begin
      vecs[i].sketch = model_sketch(vecs[i].win);
      vecs[i].lat    = N + 1;
    end
    for (int i = 0; i < 4; i++) begin
      hash_window(vecs[i].win, vecs[i].sketch, lat);
      check("hash_latency", lat, vecs[i].lat);
    end
    hash_window('0, model_sketch('0), lat);
    check("allA_sketch0", hashed_sketch[B-1:0], 0);

    // Four distinct reference windows, ids 0..3; id 0 holds is_insert for 2 cycles.
    for (int i = 0; i < 4; i++) begin
      wr[i] = rand_window();
      hash_window(wr[i], model_sketch(wr[i]), lat);
      run_op(1'b1, 1'b0, 32'(i), (i == 0) ? 2 : 1, bc);
      check("insert_busy", bc, S);
    end
    pulse_clear_stats();
    hash_window(wr[2], model_sketch(wr[2]), lat);
    @(negedge clk) is_query = 1'b1;
    @(negedge clk) is_query = 1'b0;
    repeat (3) @(negedge clk);
    calc(2);

    // Votes then clear_stats: no match left.
    run_op(1'b0, 1'b1, 0, 1, bc);
    check("query_busy", bc, S);
    pulse_clear_stats();
    calc(-1);

    // Insert and query on the same edge: insert of id 1 wins, query dropped.
    run_op(1'b1, 1'b1, 1, 1, bc);
    check("ins_qry_busy", bc, S);
    calc(-1);
    run_op(1'b0, 1'b1, 0, 1, bc);
    calc(1);

    // Async reset in the middle of an insert.
    @(negedge clk);
    window_id = 2;
    is_insert = 1'b1;
    @(negedge clk) is_insert = 1'b0;
    @(posedge clk);
    #2 reset_lsh_core_n = 1'b0;
    #1;
    check("rst_mid_insert_busy", table_busy, 0);
    check("rst_mid_insert_sketch", hashed_sketch, 0);
    @(negedge clk) reset_lsh_core_n = 1'b1;

    // Async reset in the middle of hashing.
    @(negedge clk) clear_hasher = 1'b1;
    @(negedge clk) clear_hasher = 1'b0;
    window = wr[1];
    ready_for_hashing = 1'b1;
    repeat (20) @(posedge clk);
    #2 reset_lsh_core_n = 1'b0;
    ready_for_hashing = 1'b0;
    #1;
    check("rst_run_done", hashing_is_done, 0);
    check("rst_run_sketch", hashed_sketch, 0);
    @(negedge clk) reset_lsh_core_n = 1'b1;
    hash_window(wr[2], model_sketch(wr[2]), lat);
    run_op(1'b0, 1'b1, 0, 1, bc);
    calc(-1);

    // 17 identical windows: bucket capacity 16 drops id 16, tie resolves to id 0.
    wb = rand_window();
    hash_window(wb, model_sketch(wb), lat);
    for (int id = 0; id < 17; id++) begin
      run_op(1'b1, 1'b0, 32'(id), 1, bc);
      check("insert17_busy", bc, S);
    end
    run_op(1'b1, 1'b0, 600, 1, bc);
    check("reject_busy", bc, 0);
    run_op(1'b0, 1'b1, 0, 1, bc);
    calc(0);

    // Out-of-range id leaves an empty table empty.
    do_reset();
    wx = rand_window();
    hash_window(wx, model_sketch(wx), lat);
    run_op(1'b1, 1'b0, 600, 1, bc);
    check("reject600_busy", bc, 0);
    run_op(1'b0, 1'b1, 0, 1, bc);
    calc(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
